// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small circular holding FIFO.
// Bits are paced by the shared 16x baud tick; the line output is registered.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH    = 4,
  parameter int TICKS_PER_BIT = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tick,
  input  logic       i_tx_push,
  input  logic [7:0] i_tx_data,
  output logic       o_tx_full,
  output logic       o_tx_empty,
  output logic       o_tx_busy,
  output logic       o_tx_done,
  output logic       o_tx
);

  localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = (TICKS_PER_BIT > 2) ? $clog2(TICKS_PER_BIT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          r_state;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [TW-1:0]   r_tick_cnt;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_shift;
  logic            r_tx;
  logic            r_tx_done;

  state_t          w_state_next;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_bit_end;
  logic            w_tx_next;
  logic            w_done_next;
  logic [TW-1:0]   w_tick_cnt_next;
  logic [2:0]      w_bit_cnt_next;
  logic [7:0]      w_shift_next;

  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  // Full is judged on the registered count, so a push during a pop while full is dropped.
  assign w_push    = i_tx_push && !w_full;
  assign w_bit_end = i_tick && (r_tick_cnt == TW'(TICKS_PER_BIT - 1));

  assign o_tx_full  = w_full;
  assign o_tx_empty = w_empty;
  assign o_tx_busy  = (r_state != S_IDLE) || !w_empty;
  assign o_tx_done  = r_tx_done;
  assign o_tx       = r_tx;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (!w_empty) w_state_next = S_START;
      S_START: if (w_bit_end) w_state_next = S_DATA;
      S_DATA:  if (w_bit_end && (r_bit_cnt == 3'd7)) w_state_next = S_STOP;
      S_STOP:  if (w_bit_end) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_pop           = 1'b0;
    w_tx_next       = r_tx;
    w_done_next     = 1'b0;
    w_tick_cnt_next = r_tick_cnt;
    w_bit_cnt_next  = r_bit_cnt;
    w_shift_next    = r_shift;
    if (i_tick) w_tick_cnt_next = w_bit_end ? '0 : r_tick_cnt + TW'(1);
    case (r_state)
      S_IDLE: begin
        w_tx_next       = 1'b1;
        w_tick_cnt_next = '0;
        w_bit_cnt_next  = 3'd0;
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_shift_next = r_mem[r_rd_ptr];
          w_tx_next    = 1'b0;
        end
      end
      S_START: if (w_bit_end) w_tx_next = r_shift[0];
      S_DATA: begin
        if (w_bit_end) begin
          if (r_bit_cnt == 3'd7) begin
            w_tx_next = 1'b1;
          end else begin
            w_bit_cnt_next = r_bit_cnt + 3'd1;
            w_shift_next   = {1'b0, r_shift[7:1]};
            w_tx_next      = r_shift[1];
          end
        end
      end
      S_STOP: begin
        w_tx_next = 1'b1;
        if (w_bit_end) w_done_next = 1'b1;
      end
      default: w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_tick_cnt <= '0;
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'h00;
      r_tx       <= 1'b1;
      r_tx_done  <= 1'b0;
    end else begin
      r_tick_cnt <= w_tick_cnt_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_shift    <= w_shift_next;
      r_tx       <= w_tx_next;
      r_tx_done  <= w_done_next;
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_tx_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: frame-level model checked every cycle, a 16x
// oversampling receiver on the line, and directed scenarios with literal pins.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       push = 1'b0;
  logic [7:0] data = 8'h00;
  logic       full, empty, busy, done, tx;

  uart_tx_fifo #(.FIFO_DEPTH(DEPTH), .TICKS_PER_BIT(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_tx_push(push), .i_tx_data(data),
    .o_tx_full(full), .o_tx_empty(empty), .o_tx_busy(busy), .o_tx_done(done), .o_tx(tx)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Baud tick: one clk wide, every tick_div clks.
  int tick_div = 4;
  int tcnt = 0;
  initial forever begin
    @(negedge clk);
    tcnt = (tcnt + 1 >= tick_div) ? 0 : tcnt + 1;
    tick = (tcnt == 0);
  end

  // Frame-level model: a byte queue plus the 10-bit frame currently on the line.
  byte unsigned m_q[$];
  logic         m_active;
  logic [9:0]   m_frame;
  int           m_bit, m_ticks;
  logic         m_tx, m_done, m_was_full;
  byte unsigned m_b;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q.delete();
      m_active = 1'b0;
      m_bit = 0;
      m_ticks = 0;
      m_tx = 1'b1;
      m_done = 1'b0;
    end else begin
      m_was_full = (m_q.size() == DEPTH);
      m_done = 1'b0;
      if (!m_active) begin
        if (m_q.size() != 0) begin
          m_b = m_q.pop_front();
          m_frame = {1'b1, m_b, 1'b0};
          m_active = 1'b1;
          m_bit = 0;
          m_ticks = 0;
          m_tx = 1'b0;
        end
      end else if (tick) begin
        m_ticks++;
        if (m_ticks == 16) begin
          m_ticks = 0;
          if (m_bit == 9) begin
            m_active = 1'b0;
            m_done = 1'b1;
            m_tx = 1'b1;
          end else begin
            m_bit++;
            m_tx = m_frame[m_bit];
          end
        end
      end
      if (push && !m_was_full) m_q.push_back(data);
    end
  end

  int n_done = 0;
  always @(negedge clk) begin
    if (rst) begin
      chk("tx", tx, m_tx);
      chk("tx_done", done, m_done);
      chk("tx_full", full, m_q.size() == DEPTH);
      chk("tx_empty", empty, m_q.size() == 0);
      chk("tx_busy", busy, m_active || (m_q.size() != 0));
      if (done) n_done++;
    end
  end

  // 16x oversampling receiver: start detected on a tick, then mid-bit sampling.
  byte unsigned rx_q[$];
  logic         rx_on;
  int           rx_cnt;
  logic [7:0]   rx_sh;
  int           rx_ferr = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_on = 1'b0;
      rx_cnt = 0;
    end else if (tick) begin
      if (!rx_on) begin
        if (tx == 1'b0) begin
          rx_on = 1'b1;
          rx_cnt = 0;
        end
      end else begin
        rx_cnt++;
        if (rx_cnt == 8 && tx != 1'b0) rx_on = 1'b0;
        else if (rx_cnt >= 24 && rx_cnt <= 136 && ((rx_cnt - 8) % 16) == 0) rx_sh = {tx, rx_sh[7:1]};
        else if (rx_cnt == 152) begin
          rx_on = 1'b0;
          if (tx) rx_q.push_back(rx_sh);
          else rx_ferr++;
        end
      end
    end
  end

  byte unsigned exp_q[$];

  task automatic check_rx(input string name);
    chk({name, "_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < rx_q.size()) chk({name, "_byte"}, rx_q[i], exp_q[i]);
  endtask

  task automatic push_byte(input logic [7:0] b);
    push = 1'b1;
    data = b;
    @(negedge clk);
    push = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int k = 0;
    while (busy && k < max) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", busy, 1'b0);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_done(input int max);
    int k = 0;
    while (!done && k < max) begin
      @(negedge clk);
      k++;
    end
    chk("done_timeout", done, 1'b1);
  endtask

  task automatic start_test();
    rx_q.delete();
    exp_q.delete();
    n_done = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int k;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_full", full, 1'b0);
    chk("rst_empty", empty, 1'b1);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte 0xA5: tx falls two clks after the push.
    start_test();
    push_byte(8'hA5);
    chk("a5_empty_n1", empty, 1'b0);
    chk("a5_tx_n1", tx, 1'b1);
    @(negedge clk);
    chk("a5_tx_n2", tx, 1'b0);
    wait_done(2000);
    @(negedge clk);
    chk("a5_busy_after_done", busy, 1'b0);
    wait_idle(100);
    exp_q = '{8'hA5};
    check_rx("a5_rx");
    chk("a5_done_pulses", n_done, 1);

    // Five consecutive pushes fill the FIFO; a sixth is dropped.
    start_test();
    for (int i = 0; i < 5; i++) begin
      push = 1'b1;
      data = 8'h11 + 8'(i);
      @(negedge clk);
    end
    chk("burst_full", full, 1'b1);
    data = 8'h99;
    @(negedge clk);
    push = 1'b0;
    chk("burst_full_after_drop", full, 1'b1);
    wait_idle(5000);
    exp_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    check_rx("burst_rx");
    chk("burst_done_pulses", n_done, 5);

    // Stream 12 bytes, pushing whenever not full: pointers wrap three times.
    start_test();
    idx = 0;
    k = 0;
    while (idx < 12 && k < 20000) begin
      if (!full) begin
        push = 1'b1;
        data = 8'(idx);
        exp_q.push_back(8'(idx));
        idx++;
      end else begin
        push = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    push = 1'b0;
    chk("wrap_all_pushed", idx, 12);
    wait_idle(10000);
    check_rx("wrap_rx");
    chk("wrap_done_pulses", n_done, 12);

    // Push on the pop cycle while full: dropped, count DEPTH -> DEPTH-1.
    start_test();
    for (int i = 0; i < 5; i++) begin
      push = 1'b1;
      data = 8'h21 + 8'(i);
      @(negedge clk);
    end
    push = 1'b0;
    chk("pp_full", full, 1'b1);
    wait_done(2000);
    push_byte(8'hEE);
    chk("pp_full_after", full, 1'b0);
    chk("pp_count_after", dut.r_count, 3);
    wait_idle(5000);
    exp_q = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25};
    check_rx("pp_rx");

    // Same stimulus with two entries queued: count stays at 2.
    start_test();
    push_byte(8'h31);
    @(negedge clk);
    push_byte(8'h32);
    push_byte(8'h33);
    chk("pp2_count_before", dut.r_count, 2);
    wait_done(2000);
    push_byte(8'h34);
    chk("pp2_count_after", dut.r_count, 2);
    wait_idle(5000);
    exp_q = '{8'h31, 8'h32, 8'h33, 8'h34};
    check_rx("pp2_rx");

    // Reset in the DATA bits of 0x3C with two bytes queued.
    start_test();
    push_byte(8'h3C);
    @(negedge clk);
    push_byte(8'h01);
    push_byte(8'h02);
    repeat (200) @(negedge clk);
    chk("rst_mid_in_frame", busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_tx", tx, 1'b1);
    chk("rst_mid_empty", empty, 1'b1);
    chk("rst_mid_done", done, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (300) @(negedge clk);
    chk("rst_post_tx", tx, 1'b1);
    chk("rst_post_done_pulses", n_done, 0);
    chk("rst_post_rx", rx_q.size(), 0);

    // Loopback with a different tick spacing.
    start_test();
    tick_div = 7;
    push_byte(8'h00);
    push_byte(8'hFF);
    push_byte(8'h55);
    wait_idle(8000);
    exp_q = '{8'h00, 8'hFF, 8'h55};
    check_rx("loop_rx");
    chk("loop_done_pulses", n_done, 3);
    chk("rx_framing_errors", rx_ferr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
